// File: rtl/psum_accumulator.sv
// Per-lane partial-sum accumulator feeding the output scaler; groups of N beats produce one result.
// Optional macro PSUM_ACC_SATURATE_EN: clamp lane sums and raise sticky sat_o instead of wrapping.

module psum_acc_lane #(
   parameter int psumWidth    = 16,
   parameter int elementWidth = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    first,
   input  logic [psumWidth-1:0]    psum,
   output logic [elementWidth-1:0] acc,
   output logic                    ovf
);

   logic [elementWidth-1:0] ext, base, nxt;

   assign ext  = {{(elementWidth-psumWidth){psum[psumWidth-1]}}, psum};
   // A first beat adds onto zero, so it loads the sign-extended psum and can never overflow.
   assign base = first ? '0 : acc;

`ifdef PSUM_ACC_SATURATE_EN
   logic [elementWidth:0] wide;
   assign wide = {base[elementWidth-1], base} + {ext[elementWidth-1], ext};
   assign ovf  = wide[elementWidth] ^ wide[elementWidth-1];
   assign nxt  = !ovf              ? wide[elementWidth-1:0] :
                 wide[elementWidth] ? {1'b1, {(elementWidth-1){1'b0}}} :
                                      {1'b0, {(elementWidth-1){1'b1}}};
`else
   assign nxt = base + ext;
   assign ovf = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       acc <= '0;
      else if (load) acc <= nxt;
   end

endmodule

module psum_accumulator #(
   parameter int numElements  = 4,
   parameter int psumWidth    = 16,
   parameter int elementWidth = 20
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear_i,
   input  logic [7:0]                          cfg_num_accum_i,
   input  logic [numElements*psumWidth-1:0]    psum_i,
   input  logic                                psum_valid_i,
   output logic                                psum_ready_o,
   output logic [numElements*elementWidth-1:0] wx_o,
   output logic                                wx_valid_o,
   input  logic                                wx_ready_i,
   output logic [15:0]                         group_cnt_o,
   output logic [numElements-1:0]              sat_o
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t                 state;
   logic [7:0]             beat_cnt, num_lat, cfg_eff, n_cur;
   logic                   first, accept, last, done;
   logic [numElements-1:0] ovf;

   assign cfg_eff = (cfg_num_accum_i == 8'd0) ? 8'd1 : cfg_num_accum_i;
   assign first   = (beat_cnt == 8'd0);
   // The group length is taken live on the first beat and from the latch afterwards.
   assign n_cur   = first ? cfg_eff : num_lat;
   assign accept  = psum_valid_i && (state == ACCUM) && !clear_i;
   assign last    = (beat_cnt + 8'd1) == n_cur;
   assign done    = (state == HOLD) && wx_ready_i && !clear_i;

   assign psum_ready_o = (state == ACCUM);
   assign wx_valid_o   = (state == HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ACCUM;
         beat_cnt    <= 8'd0;
         num_lat     <= 8'd1;
         group_cnt_o <= 16'd0;
         sat_o       <= '0;
      end else if (clear_i) begin
         state    <= ACCUM;
         beat_cnt <= 8'd0;
         sat_o    <= '0;
      end else begin
         if (accept) begin
            if (first) num_lat <= cfg_eff;
            sat_o <= sat_o | ovf;
            if (last) begin
               state    <= HOLD;
               beat_cnt <= 8'd0;
            end else begin
               beat_cnt <= beat_cnt + 8'd1;
            end
         end
         if (done) begin
            state       <= ACCUM;
            group_cnt_o <= group_cnt_o + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < numElements; g++) begin : g_lane
      psum_acc_lane #(
         .psumWidth   (psumWidth),
         .elementWidth(elementWidth)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .load (accept),
         .first(first),
         .psum (psum_i[g*psumWidth +: psumWidth]),
         .acc  (wx_o[g*elementWidth +: elementWidth]),
         .ovf  (ovf[g])
      );
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: vector table of whole groups plus hand-written
// sequences for saturation, clear and reset-in-HOLD.

module tb_psum_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_i = 1'b0;
   logic [7:0]  cfg_num_accum_i = 8'd0;
   logic [63:0] psum_i = '0;
   logic        psum_valid_i = 1'b0;
   logic        psum_ready_o;
   logic [79:0] wx_o;
   logic        wx_valid_o;
   logic        wx_ready_i = 1'b0;
   logic [15:0] group_cnt_o;
   logic [3:0]  sat_o;

   int n_cmp = 0;
   int n_err = 0;
   int exp_gc = 0;

   always #5 clk = ~clk;

   psum_accumulator #(.numElements(4), .psumWidth(16), .elementWidth(20)) dut (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (clear_i),
      .cfg_num_accum_i(cfg_num_accum_i),
      .psum_i         (psum_i),
      .psum_valid_i   (psum_valid_i),
      .psum_ready_o   (psum_ready_o),
      .wx_o           (wx_o),
      .wx_valid_o     (wx_valid_o),
      .wx_ready_i     (wx_ready_i),
      .group_cnt_o    (group_cnt_o),
      .sat_o          (sat_o)
   );

   typedef struct {
      logic [7:0]            cfg;
      int                    nb;
      logic [3:0][3:0][15:0] beats;
      logic [3:0][19:0]      ew;
      int                    hold;
   } vec_t;

   vec_t tbl[5];

   function automatic logic [3:0][15:0] mk(input int a, input int b, input int c, input int d);
      logic [3:0][15:0] r;
      r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
      return r;
   endfunction

   function automatic logic [3:0][19:0] mkw(input int a, input int b, input int c, input int d);
      logic [3:0][19:0] r;
      r[0] = 20'(a); r[1] = 20'(b); r[2] = 20'(c); r[3] = 20'(d);
      return r;
   endfunction

   task automatic check(input string nm, input logic [79:0] a, input logic [79:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   // Called at #1 after an edge; returns at #1 after the edge that accepted the beat.
   task automatic send_beat(input logic [63:0] b, input logic [7:0] cfg);
      int t = 0;
      psum_i = b;
      cfg_num_accum_i = cfg;
      psum_valid_i = 1'b1;
      while (!psum_ready_o && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) check("ready_timeout", {79'd0, psum_ready_o}, 80'd1);
      @(posedge clk); #1;
      psum_valid_i = 1'b0;
   endtask

   task automatic expect_group(input string nm, input logic [79:0] ew, input logic [3:0] es,
                               input int hold);
      check({nm, "_valid"}, {79'd0, wx_valid_o}, 80'd1);
      check({nm, "_pready"}, {79'd0, psum_ready_o}, 80'd0);
      check({nm, "_wx"}, wx_o, ew);
      check({nm, "_sat"}, {76'd0, sat_o}, {76'd0, es});
      for (int h = 0; h < hold; h++) begin
         wx_ready_i = 1'b0;
         psum_i = 64'hDEAD_BEEF_0BAD_F00D;
         psum_valid_i = 1'b1;
         @(posedge clk); #1;
         check($sformatf("%s_hold%0d_wx", nm, h), wx_o, ew);
         check($sformatf("%s_hold%0d_pready", nm, h), {79'd0, psum_ready_o}, 80'd0);
         check($sformatf("%s_hold%0d_valid", nm, h), {79'd0, wx_valid_o}, 80'd1);
      end
      psum_valid_i = 1'b0;
      wx_ready_i = 1'b1;
      @(posedge clk); #1;
      wx_ready_i = 1'b0;
      exp_gc++;
      check({nm, "_valid_drop"}, {79'd0, wx_valid_o}, 80'd0);
      check({nm, "_pready_back"}, {79'd0, psum_ready_o}, 80'd1);
      check({nm, "_gcnt"}, {64'd0, group_cnt_o}, 80'(exp_gc));
   endtask

   initial begin
      logic [3:0] sat_exp;
      logic [79:0] sat_wx;

      tbl[0].cfg = 8'd3; tbl[0].nb = 3; tbl[0].hold = 0;
      tbl[0].beats[0] = mk(1, 2, 3, 4);
      tbl[0].beats[1] = mk(10, 20, 30, 40);
      tbl[0].beats[2] = mk(-1, -2, -3, -4);
      tbl[0].beats[3] = '0;
      tbl[0].ew = mkw(10, 20, 30, 40);
      tbl[1] = tbl[0];
      tbl[1].hold = 5;
      tbl[2].cfg = 8'd0; tbl[2].nb = 1; tbl[2].hold = 0;
      tbl[2].beats = '0;
      tbl[2].beats[0] = mk(5, -5, 7, -7);
      tbl[2].ew = mkw(5, -5, 7, -7);
      tbl[3].cfg = 8'd0; tbl[3].nb = 1; tbl[3].hold = 2;
      tbl[3].beats = '0;
      tbl[3].beats[0] = mk(-100, 100, 0, 32767);
      tbl[3].ew = mkw(-100, 100, 0, 32767);
      tbl[4].cfg = 8'd4; tbl[4].nb = 4; tbl[4].hold = 1;
      for (int j = 0; j < 4; j++) tbl[4].beats[j] = mk(100, -200, 300, -32768);
      tbl[4].ew = mkw(400, -800, 1200, -131072);

      // Reset values while rst is held
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {79'd0, wx_valid_o}, 80'd0);
      check("rst_pready", {79'd0, psum_ready_o}, 80'd1);
      check("rst_gcnt", {64'd0, group_cnt_o}, 80'd0);
      check("rst_sat", {76'd0, sat_o}, 80'd0);
      check("rst_wx", wx_o, 80'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 5; k++) begin
         wx_ready_i = (tbl[k].hold == 0);
         for (int j = 0; j < tbl[k].nb; j++)
            send_beat(tbl[k].beats[j], (j == 0) ? tbl[k].cfg : ~tbl[k].cfg);
         expect_group($sformatf("vec%0d", k), tbl[k].ew, 4'd0, tbl[k].hold);
      end

      // Saturation / wrap with 32 beats of full-scale positive input
`ifdef PSUM_ACC_SATURATE_EN
      sat_exp = 4'b1111;
      sat_wx  = mkw(524287, 524287, 524287, 524287);
`else
      sat_exp = 4'b0000;
      sat_wx  = mkw(-32, -32, -32, -32);
`endif
      for (int j = 0; j < 32; j++) send_beat(mk(32767, 32767, 32767, 32767), 8'd32);
      expect_group("sat", sat_wx, sat_exp, 0);
      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
      check("sat_cleared", {76'd0, sat_o}, 80'd0);
      check("sat_clear_gcnt", {64'd0, group_cnt_o}, 80'(exp_gc));

      // Clear mid-group, with a valid beat on the clear cycle that must be dropped
      send_beat(mk(9, 9, 9, 9), 8'd4);
      send_beat(mk(9, 9, 9, 9), 8'd4);
      clear_i = 1'b1;
      psum_i = mk(50, 50, 50, 50);
      psum_valid_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
      psum_valid_i = 1'b0;
      check("clr_pready", {79'd0, psum_ready_o}, 80'd1);
      check("clr_valid", {79'd0, wx_valid_o}, 80'd0);
      for (int j = 0; j < 3; j++) send_beat(mk(1, 1, 1, 1), 8'd4);
      check("clr_not_early", {79'd0, wx_valid_o}, 80'd0);
      send_beat(mk(1, 1, 1, 1), 8'd4);
      expect_group("clr", mkw(4, 4, 4, 4), 4'd0, 0);

      // Reset while a result is held, then while a group is partial
      send_beat(mk(7, 7, 7, 7), 8'd2);
      send_beat(mk(7, 7, 7, 7), 8'd2);
      check("rh_valid_before", {79'd0, wx_valid_o}, 80'd1);
      #2 rst = 1'b1;
      #1;
      check("rh_valid_async", {79'd0, wx_valid_o}, 80'd0);
      check("rh_gcnt_async", {64'd0, group_cnt_o}, 80'd0);
      check("rh_wx_async", wx_o, 80'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_gc = 0;
      send_beat(mk(100, 100, 100, 100), 8'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send_beat(mk(3, 3, 3, 3), 8'd2);
      check("rh_not_early", {79'd0, wx_valid_o}, 80'd0);
      send_beat(mk(3, 3, 3, 3), 8'd2);
      expect_group("rh", mkw(6, 6, 6, 6), 4'd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
